// File: rtl/fifo_16_32_rf_pkg.sv
// fifo_16_32_rf_pkg: shared sizes and types for the 16x32 FIFO controller
package fifo_16_32_rf_pkg;
    localparam int FIFO_DEPTH       = 16;
    localparam int FIFO_PTR_WIDTH   = 4;
    localparam int FIFO_COUNT_WIDTH = 5;
    localparam int FIFO_DATA_WIDTH  = 32;
    typedef logic [FIFO_DATA_WIDTH-1:0]  data_t;
    typedef logic [FIFO_PTR_WIDTH-1:0]   ptr_t;
    typedef logic [FIFO_COUNT_WIDTH-1:0] count_t;
endpackage

// File: rtl/fifo_16_32_rf_if.sv
// fifo_16_32_rf_if: push/pop handshakes, flush, occupancy and status flags
interface fifo_16_32_rf_if;
    import fifo_16_32_rf_pkg::*;
    logic   fifo_flush;
    logic   push_valid;
    data_t  push_data;
    logic   push_ready;
    logic   pop_valid;
    data_t  pop_data;
    logic   pop_ready;
    count_t fifo_count;
    logic   fifo_almost_full;
    logic   fifo_almost_empty;
    logic   fifo_overflow;
    logic   fifo_underflow;
    modport master (
        output fifo_flush, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, fifo_count,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );
    modport slave (
        input  fifo_flush, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, fifo_count,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_16_32_rf_storage.sv
// rf_1r_1w_16_32: 16x32 register file, one combinational read port, one write port, contents not reset
module rf_1r_1w_16_32
    import fifo_16_32_rf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  ptr_t  rd_addr_0,
    output data_t rd_data_0,
    input  logic  wr_en,
    input  ptr_t  wr_addr,
    input  data_t wr_data
);
    data_t mem_q [FIFO_DEPTH];
    assign rd_data_0 = mem_q[rd_addr_0];
    // write port; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_addr] <= wr_data;
    end
endmodule

// File: rtl/fifo_16_32_rf.sv
// fifo_16_32_rf: 16x32 FIFO controller with pointers, count-based full/empty, flush and sticky error flags
module fifo_16_32_rf
    import fifo_16_32_rf_pkg::*;
#(
    parameter int unsigned ALMOST_FULL_LEVEL  = 12,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
    input logic fifo_clock,
    input logic fifo_reset,
    fifo_16_32_rf_if.slave bus
);
    localparam count_t AF_LEVEL = count_t'(ALMOST_FULL_LEVEL);
    localparam count_t AE_LEVEL = count_t'(ALMOST_EMPTY_LEVEL);
    ptr_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    count_t count_q, count_d;
    logic   overflow_q, overflow_d, underflow_q, underflow_d;
    logic   full, empty, push_acc, pop_acc, wr_en;
    data_t  rd_data;
    assign full     = count_q == count_t'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign push_acc = bus.push_valid & ~full;
    assign pop_acc  = bus.pop_ready & ~empty;
    assign wr_en    = push_acc & ~bus.fifo_flush;
    assign bus.push_ready        = ~full;
    assign bus.pop_valid         = ~empty;
    assign bus.pop_data          = rd_data;
    assign bus.fifo_count        = count_q;
    assign bus.fifo_almost_full  = count_q >= AF_LEVEL;
    assign bus.fifo_almost_empty = count_q <= AE_LEVEL;
    assign bus.fifo_overflow     = overflow_q;
    assign bus.fifo_underflow    = underflow_q;
    // next state: flush clears everything, otherwise advance on accepted transfers
    always_comb begin
        wr_ptr_d    = bus.fifo_flush ? '0 : wr_ptr_q + ptr_t'(push_acc);
        rd_ptr_d    = bus.fifo_flush ? '0 : rd_ptr_q + ptr_t'(pop_acc);
        count_d     = bus.fifo_flush ? '0 : count_q + count_t'(push_acc) - count_t'(pop_acc);
        overflow_d  = bus.fifo_flush ? 1'b0 : overflow_q | (bus.push_valid & full);
        underflow_d = bus.fifo_flush ? 1'b0 : underflow_q | (bus.pop_ready & empty);
    end
    // state registers
    always_ff @(posedge fifo_clock or posedge fifo_reset) begin
        if (fifo_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    rf_1r_1w_16_32 u_rf (
        .clk       (fifo_clock),
        .rst       (fifo_reset),
        .rd_addr_0 (rd_ptr_q),
        .rd_data_0 (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_ptr_q),
        .wr_data   (bus.push_data)
    );
endmodule

// File: tb/tb_fifo_16_32_rf.sv
// tb_fifo_16_32_rf: vector table, directed corner sequences and random traffic against a queue model
module tb_fifo_16_32_rf;
    localparam int AF = 12;
    localparam int AE = 2;
    logic fifo_clock, fifo_reset;
    fifo_16_32_rf_if bus();
    fifo_16_32_rf #(.ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)) dut (
        .fifo_clock (fifo_clock),
        .fifo_reset (fifo_reset),
        .bus        (bus)
    );
    initial fifo_clock = 1'b0;
    always #5 fifo_clock = ~fifo_clock;

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        pr;
        logic        fl;
        int          cnt;
        logic        pvld;
        logic [31:0] head;
        logic        udf;
    } vec_t;
    vec_t tbl [8];

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] q [$];
    bit m_ovf = 0;
    bit m_udf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(bus.fifo_count), 32'(q.size()));
        chk("push_ready", 32'(bus.push_ready), 32'(q.size() < 16));
        chk("pop_valid", 32'(bus.pop_valid), 32'(q.size() > 0));
        chk("almost_full", 32'(bus.fifo_almost_full), 32'(q.size() >= AF));
        chk("almost_empty", 32'(bus.fifo_almost_empty), 32'(q.size() <= AE));
        chk("overflow", 32'(bus.fifo_overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.fifo_underflow), 32'(m_udf));
        if (q.size() > 0) chk("pop_data", bus.pop_data, q[0]);
    endtask

    task automatic cycle(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
        bit pa, ra;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        bus.fifo_flush = fl;
        @(negedge fifo_clock);
        check_model();
        @(posedge fifo_clock);
        pa = pv && q.size() < 16;
        ra = pr && q.size() > 0;
        if (fl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (pv && q.size() == 16) m_ovf = 1;
            if (pr && q.size() == 0) m_udf = 1;
            if (ra) void'(q.pop_front());
            if (pa) q.push_back(pd);
        end
        #1;
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        bus.fifo_flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(bus.fifo_count), 0);
        chk({tag, "_push_ready"}, 32'(bus.push_ready), 1);
        chk({tag, "_pop_valid"}, 32'(bus.pop_valid), 0);
        chk({tag, "_almost_empty"}, 32'(bus.fifo_almost_empty), 1);
        chk({tag, "_almost_full"}, 32'(bus.fifo_almost_full), 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 32'h11, 1'b0};
        tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 2, 1'b1, 32'h11, 1'b0};
        tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 2, 1'b1, 32'h22, 1'b0};
        tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1'b1, 32'h33, 1'b0};
        tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 32'h0,  1'b0};
        tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 32'h0,  1'b1};
        tbl[6] = '{1'b1, 32'h44, 1'b0, 1'b1, 0, 1'b0, 32'h0,  1'b0};
        tbl[7] = '{1'b1, 32'h55, 1'b0, 1'b0, 1, 1'b1, 32'h55, 1'b0};
        fifo_reset = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        bus.fifo_flush = 1'b0;
        repeat (2) @(posedge fifo_clock);
        #1;
        check_reset_outputs("reset");
        chk("reset_overflow", 32'(bus.fifo_overflow), 0);
        chk("reset_underflow", 32'(bus.fifo_underflow), 0);
        @(negedge fifo_clock);
        fifo_reset = 1'b0;
        @(posedge fifo_clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].pv, tbl[i].pd, tbl[i].pr, tbl[i].fl);
            chk($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_pop_valid", i), 32'(bus.pop_valid), 32'(tbl[i].pvld));
            chk($sformatf("vec%0d_underflow", i), 32'(bus.fifo_underflow), 32'(tbl[i].udf));
            if (tbl[i].pvld) chk($sformatf("vec%0d_head", i), bus.pop_data, tbl[i].head);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(bus.fifo_count), 16);
        chk("fill_push_ready", 32'(bus.push_ready), 0);
        chk("fill_almost_full", 32'(bus.fifo_almost_full), 1);
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        chk("over_flag", 32'(bus.fifo_overflow), 1);
        chk("over_count", 32'(bus.fifo_count), 16);

        for (int i = 1; i <= 16; i++) begin
            bus.pop_ready = 1'b1;
            @(negedge fifo_clock);
            chk($sformatf("drain_data%0d", i), bus.pop_data, 32'(i));
            @(posedge fifo_clock);
            #1;
            void'(q.pop_front());
        end
        bus.pop_ready = 1'b0;
        chk("drain_count", 32'(bus.fifo_count), 0);
        chk("drain_pop_valid", 32'(bus.pop_valid), 0);
        chk("drain_almost_empty", 32'(bus.fifo_almost_empty), 1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'hA5A50000 + 32'(i), 1'b1, 1'b0);
            chk($sformatf("stream_count%0d", i), 32'(bus.fifo_count), 1);
        end
        chk("stream_underflow", 32'(bus.fifo_underflow), 1);
        chk("stream_head", bus.pop_data, 32'hA5A50027);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) cycle(1'b1, 32'hB0000000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hC0000000, 1'b1, 1'b0);
        chk("fullboth_count", 32'(bus.fifo_count), 15);
        chk("fullboth_head", bus.pop_data, 32'hB0000001);
        chk("fullboth_overflow", 32'(bus.fifo_overflow), 1);
        cycle(1'b1, 32'hC0000001, 1'b1, 1'b0);
        chk("fullboth2_count", 32'(bus.fifo_count), 15);
        chk("fullboth2_head", bus.pop_data, 32'hB0000002);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hD0000000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h77777777, 1'b0, 1'b1);
        chk("flush_count", 32'(bus.fifo_count), 0);
        chk("flush_pop_valid", 32'(bus.pop_valid), 0);
        chk("flush_overflow", 32'(bus.fifo_overflow), 0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("after_flush_pop_valid", 32'(bus.pop_valid), 1);
        chk("after_flush_data", bus.pop_data, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hE0000000 + 32'(i), 1'b0, 1'b0);
        chk("preareset_count", 32'(bus.fifo_count), 5);
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hFFFF0000;
        #2;
        fifo_reset = 1'b1;
        #1;
        check_reset_outputs("async");
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        @(negedge fifo_clock);
        bus.push_valid = 1'b0;
        fifo_reset = 1'b0;
        @(posedge fifo_clock);
        #1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bit push_phase;
            push_phase = ((i / 60) % 2) == 0;
            cycle($urandom_range(0, 3) < (push_phase ? 3 : 1), $urandom,
                  $urandom_range(0, 3) < (push_phase ? 1 : 3), $urandom_range(0, 63) == 0);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_16_32_rf.md
Name: fifo_16_32_rf

Overview:
- 16-entry x 32-bit synchronous FIFO controller that pairs a writer (push side) with a reader (pop side) over the existing 16x32 one-read one-write register file storage.
- Owns the write pointer, read pointer, occupancy count, handshakes, flush and error flags.
- Used as the standard buffer between producer and consumer blocks in the emulation/xilinx macro set.

Parameters:
- ALMOST_FULL_LEVEL, 12, occupancy at or above which fifo_almost_full is asserted (range 1..16).
- ALMOST_EMPTY_LEVEL, 2, occupancy at or below which fifo_almost_empty is asserted (range 0..15).

Ports:
- fifo_clock  input  1  single clock; all state updates on its rising edge.
- fifo_reset  input  1  asynchronous, active-high reset.
- fifo_flush  input  1  synchronous clear of the FIFO contents.
- push_valid  input  1  writer offers push_data this cycle.
- push_data  input  32  write data.
- push_ready  output  1  FIFO can accept a push this cycle.
- pop_valid  output  1  pop_data holds the head entry.
- pop_data  output  32  head entry.
- pop_ready  input  1  reader takes the head entry this cycle.
- fifo_count  output  5  occupancy, 0..16.
- fifo_almost_full  output  1  fifo_count >= ALMOST_FULL_LEVEL.
- fifo_almost_empty  output  1  fifo_count <= ALMOST_EMPTY_LEVEL.
- fifo_overflow  output  1  sticky: push_valid seen while full.
- fifo_underflow  output  1  sticky: pop_ready seen while empty.

Behaviour:
- Reset (async, fifo_reset=1):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs during reset: push_ready=1, pop_valid=0, fifo_count=0, almost_empty=1, almost_full=0.
  - Storage contents are not cleared and are undefined after reset.
- Pointers are 4-bit and wrap 15->0 naturally. Count is 5-bit and is the sole full/empty source: full = (count==16), empty = (count==0).
- push_ready = !full and pop_valid = !empty. Both are combinational from registered count only, never from the peer's valid or ready.
- Push accepted = push_valid & push_ready. On acceptance, storage write enable is asserted with address wr_ptr and data push_data; wr_ptr increments on the same edge.
- Pop accepted = pop_valid & pop_ready. On acceptance, rd_ptr increments.
- pop_data is the storage's combinational read at rd_ptr. It is valid whenever pop_valid=1 and X-don't-care otherwise.
- Latency: data pushed at edge N is visible on pop_data with pop_valid=1 from cycle N+1 (one cycle, zero bubbles).
- Count update: +1 for push only, -1 for pop only, unchanged when both or neither are accepted.
- Full with push_valid and pop_ready both high: the pop is accepted and the push is not (push_ready=0 that cycle). Count becomes 15. overflow is set.
- Empty with push_valid and pop_ready both high: the push is accepted and the pop is not. Count becomes 1. underflow is set.
- Overflow and underflow are sticky until reset or flush. They never alter pointers.
- fifo_flush=1: wr_ptr, rd_ptr and count are cleared to 0, and overflow and underflow are cleared. Any push or pop in that cycle is discarded (storage write enable is forced low). Flush has priority over all other events.
- Reset asserted mid-transfer: the in-flight push is lost. After deassertion the FIFO is empty.
- almost_full and almost_empty are combinational from count.

Decomposition:
- Shared package: FIFO_DEPTH=16, FIFO_PTR_WIDTH=4, FIFO_COUNT_WIDTH=5, FIFO_DATA_WIDTH=32.
- One sub-module: the storage instance rf_1r_1w_16_32.
  - Wiring: clock from fifo_clock, reset from fifo_reset, rd_addr_0 from rd_ptr, write enable from accepted push and not flush, write address from wr_ptr, write data from push_data.
- Pointer, count and flag logic stay in this module.

Test Plan:
- Reset, then push 0x00000001..0x00000010 on 16 consecutive cycles with pop_ready=0 -> fifo_count=16, push_ready=0, almost_full high from count 12; a 17th push_valid sets fifo_overflow=1 and count stays 16.
- From full, pop_ready=1 for 16 cycles -> pop_data sequence 0x00000001..0x00000010 in order, pop_valid falls after the 16th pop, count=0, almost_empty high at count<=2.
- Empty FIFO with push_valid=1, pop_ready=1 continuously, data=0xA5A50000+i -> first cycle push only (underflow set); thereafter one push and one pop per cycle, count steady at 1, data in order, pointers wrap past 15 without loss over 40 cycles.
- Full FIFO with push_valid=1, pop_ready=1 -> head popped, push rejected, count=15; next cycle push accepted and pop accepted, count stays 15.
- 8 entries loaded, fifo_flush=1 together with push_valid=1 -> next cycle count=0, pop_valid=0, flags cleared; a subsequent push of 0xDEADBEEF appears on pop_data one cycle later.
- Assert fifo_reset asynchronously mid-cycle with 5 entries held -> outputs immediately go to reset values (count=0, pop_valid=0, push_ready=1) without waiting for a clock edge.
